// File: rtl/hazard_scoreboard_if.sv
// Decode-stage issue bus between the decoder and the hazard scoreboard.
// The decoder (master) presents the candidate instruction. The scoreboard
// (slave) answers with the stall decision, the operand forwarding selects
// and the count of in-flight results.
interface hazard_scoreboard_if #(
  parameter int REG_BITS = 5
);
  logic                issue_valid;
  logic                issue_we;
  logic                issue_is_load;
  logic [REG_BITS-1:0] issue_rd;
  logic [REG_BITS-1:0] issue_rs1;
  logic [REG_BITS-1:0] issue_rs2;
  logic                issue_rs1_used;
  logic                issue_rs2_used;
  logic                flush;
  logic                stall;
  logic [1:0]          fwd1;
  logic [1:0]          fwd2;
  logic [REG_BITS:0]   pending_cnt;

  modport master (
    output issue_valid, issue_we, issue_is_load, issue_rd, issue_rs1, issue_rs2,
           issue_rs1_used, issue_rs2_used, flush,
    input  stall, fwd1, fwd2, pending_cnt
  );

  modport slave (
    input  issue_valid, issue_we, issue_is_load, issue_rd, issue_rs1, issue_rs2,
           issue_rs1_used, issue_rs2_used, flush,
    output stall, fwd1, fwd2, pending_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for an in-order pipeline.
//
// Each architectural register has one entry with two fields:
// - rem: the number of cycles left until the register's value can be forwarded.
// - age: the number of cycles since it became forwardable. Age saturates at
//   FWD_DEPTH, which means the register file now holds the value.
//
// A producer with latency L is written with rem = L-1. The edge that records
// the issue also counts as the first elapsed cycle. A consumer issued right
// after an ALU producer (L=1) therefore sees rem=0 and forwards from stage 1.
// The WAW check compares the old entry's rem against the new producer's
// latency. The new entry is not stored as L-1 when this check is made.
//
// The bus interface must be instantiated with the same REG_BITS as this module.
module hazard_scoreboard #(
  parameter int REG_BITS  = 5,
  parameter int ALU_LAT   = 1,
  parameter int LOAD_LAT  = 2,
  parameter int FWD_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  hazard_scoreboard_if.slave  bus
);

  localparam int NREGS = 2 ** REG_BITS;
  localparam int CW    = REG_BITS + 1;

  localparam logic [2:0] ALU_LAT3  = 3'(ALU_LAT);
  localparam logic [2:0] LOAD_LAT3 = 3'(LOAD_LAT);
  localparam logic [2:0] ALU_REM   = 3'(ALU_LAT - 1);
  localparam logic [2:0] LOAD_REM  = 3'(LOAD_LAT - 1);
  localparam logic [1:0] AGE_MAX   = 2'(FWD_DEPTH);

  logic [2:0]    rem_r      [NREGS];
  logic [1:0]    age_r      [NREGS];
  logic [2:0]    rem_nxt_s  [NREGS];
  logic [1:0]    age_nxt_s  [NREGS];
  logic [CW-1:0] pend_r;
  logic [CW-1:0] pend_nxt_s;

  logic          raw1_s;
  logic          raw2_s;
  logic          waw_s;
  logic          stall_s;
  logic          write_s;
  logic [2:0]    new_lat_s;
  logic [2:0]    write_rem_s;
  logic [1:0]    fwd1_s;
  logic [1:0]    fwd2_s;

  // Operand source for one read port. The register file is the source when
  // the port is unused, reads r0, the value is still in flight, or the value
  // has already retired from the forwarding network.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_BITS-1:0] src,
                                         input logic [2:0] rem, input logic [1:0] age);
    logic [1:0] sel;
    if (!used || (src == {REG_BITS{1'b0}}) || (rem != 3'd0) || (age >= AGE_MAX)) begin
      sel = 2'd0;
    end else begin
      sel = age + 2'd1;
    end
    return sel;
  endfunction

  // Hazard detection against the pre-update entry state; flush masks stall.
  always_comb begin
    raw1_s      = bus.issue_rs1_used && (bus.issue_rs1 != {REG_BITS{1'b0}}) &&
                  (rem_r[bus.issue_rs1] != 3'd0);
    raw2_s      = bus.issue_rs2_used && (bus.issue_rs2 != {REG_BITS{1'b0}}) &&
                  (rem_r[bus.issue_rs2] != 3'd0);
    new_lat_s   = bus.issue_is_load ? LOAD_LAT3 : ALU_LAT3;
    write_rem_s = bus.issue_is_load ? LOAD_REM : ALU_REM;
    waw_s       = bus.issue_we && (bus.issue_rd != {REG_BITS{1'b0}}) &&
                  (rem_r[bus.issue_rd] > new_lat_s);
    if (bus.flush) begin
      stall_s = 1'b0;
    end else begin
      stall_s = bus.issue_valid && (raw1_s || raw2_s || waw_s);
    end
    write_s = bus.issue_valid && !stall_s && !bus.flush && bus.issue_we &&
              (bus.issue_rd != {REG_BITS{1'b0}});
    fwd1_s  = fwd_sel(bus.issue_rs1_used, bus.issue_rs1, rem_r[bus.issue_rs1], age_r[bus.issue_rs1]);
    fwd2_s  = fwd_sel(bus.issue_rs2_used, bus.issue_rs2, rem_r[bus.issue_rs2], age_r[bus.issue_rs2]);
  end

  // Per-entry next state and the post-update count of in-flight entries.
  always_comb begin
    pend_nxt_s = {CW{1'b0}};
    for (int r = 0; r < NREGS; r++) begin
      if ((r == 0) || bus.flush) begin
        rem_nxt_s[r] = 3'd0;
        age_nxt_s[r] = AGE_MAX;
      end else if (write_s && (bus.issue_rd == REG_BITS'(r))) begin
        rem_nxt_s[r] = write_rem_s;
        age_nxt_s[r] = 2'd0;
      end else if (rem_r[r] != 3'd0) begin
        rem_nxt_s[r] = rem_r[r] - 3'd1;
        age_nxt_s[r] = age_r[r];
      end else if (age_r[r] < AGE_MAX) begin
        rem_nxt_s[r] = 3'd0;
        age_nxt_s[r] = age_r[r] + 2'd1;
      end else begin
        rem_nxt_s[r] = 3'd0;
        age_nxt_s[r] = age_r[r];
      end
      if (rem_nxt_s[r] != 3'd0) begin
        pend_nxt_s = pend_nxt_s + CW'(1);
      end else begin
        pend_nxt_s = pend_nxt_s;
      end
    end
  end

  // Scoreboard state and pending count; reset leaves every register clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        rem_r[r] <= 3'd0;
        age_r[r] <= AGE_MAX;
      end
      pend_r <= {CW{1'b0}};
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        rem_r[r] <= rem_nxt_s[r];
        age_r[r] <= age_nxt_s[r];
      end
      pend_r <= pend_nxt_s;
    end
  end

  assign bus.stall       = stall_s;
  assign bus.fwd1        = fwd1_s;
  assign bus.fwd2        = fwd2_s;
  assign bus.pending_cnt = pend_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// dut_a uses the default latencies. dut_b uses LOAD_LAT=3.
// Only the DUT selected by tgt sees valid and flush; the other one idles.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   tgt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_BITS(5)) bus_a ();
  hazard_scoreboard_if #(.REG_BITS(5)) bus_b ();

  hazard_scoreboard #(.REG_BITS(5)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  hazard_scoreboard #(.REG_BITS(5), .LOAD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // Expected response for one decode cycle; -1 marks a don't-care field.
  typedef struct {
    string tag;
    int    stall;
    int    f1;
    int    f2;
    int    pend;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic drive(input bit v, input bit we, input bit ld, input int rd,
                       input int rs1, input bit u1, input int rs2, input bit u2, input bit fl);
    bus_a.issue_valid    = v && (tgt == 0);
    bus_a.flush          = fl && (tgt == 0);
    bus_b.issue_valid    = v && (tgt == 1);
    bus_b.flush          = fl && (tgt == 1);
    bus_a.issue_we       = we;
    bus_b.issue_we       = we;
    bus_a.issue_is_load  = ld;
    bus_b.issue_is_load  = ld;
    bus_a.issue_rd       = 5'(rd);
    bus_b.issue_rd       = 5'(rd);
    bus_a.issue_rs1      = 5'(rs1);
    bus_b.issue_rs1      = 5'(rs1);
    bus_a.issue_rs2      = 5'(rs2);
    bus_b.issue_rs2      = 5'(rs2);
    bus_a.issue_rs1_used = u1;
    bus_b.issue_rs1_used = u1;
    bus_a.issue_rs2_used = u2;
    bus_b.issue_rs2_used = u2;
  endtask

  function automatic int cur_stall();
    return (tgt == 0) ? int'(bus_a.stall) : int'(bus_b.stall);
  endfunction
  function automatic int cur_f1();
    return (tgt == 0) ? int'(bus_a.fwd1) : int'(bus_b.fwd1);
  endfunction
  function automatic int cur_f2();
    return (tgt == 0) ? int'(bus_a.fwd2) : int'(bus_b.fwd2);
  endfunction
  function automatic int cur_pend();
    return (tgt == 0) ? int'(bus_a.pending_cnt) : int'(bus_b.pending_cnt);
  endfunction

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic observe();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, ".stall"}, cur_stall(), e.stall);
      if (e.f1 >= 0) check({e.tag, ".fwd1"}, cur_f1(), e.f1);
      if (e.f2 >= 0) check({e.tag, ".fwd2"}, cur_f2(), e.f2);
      @(posedge clk);
      #1;
      if (e.pend >= 0) check({e.tag, ".pend"}, cur_pend(), e.pend);
    end
  endtask

  // One decode cycle: drive at the falling edge, queue the expectation, then
  // check the combinational outputs before the edge and the count after it.
  task automatic cyc(input string tag, input bit v, input bit we, input bit ld, input int rd,
                     input int rs1, input bit u1, input int rs2, input bit u2, input bit fl,
                     input int st, input int f1, input int f2, input int pend);
    exp_t e;
    @(negedge clk);
    drive(v, we, ld, rd, rs1, u1, rs2, u2, fl);
    e.tag = tag; e.stall = st; e.f1 = f1; e.f2 = f2; e.pend = pend;
    exp_q.push_back(e);
    #2;
    observe();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 0, 5, 1'b1, 6, 1'b1, 1'b0);
    #3;
    check("rst.stall", int'(bus_a.stall), 0);
    check("rst.fwd1", int'(bus_a.fwd1), 0);
    check("rst.fwd2", int'(bus_a.fwd2), 0);
    check("rst.pend", int'(bus_a.pending_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    //    tag        v  we ld rd rs1 u1 rs2 u2 fl   st  f1  f2  pend
    // ALU producer, then forwarding from stages 1 and 2, then the register file.
    cyc("alu.issue", 1, 1, 0, 5, 0, 0, 0, 0, 0,   0,  0,  0,  0);
    cyc("alu.dep1",  1, 1, 0, 6, 5, 1, 0, 0, 0,   0,  1,  0,  0);
    cyc("alu.dep2",  1, 0, 0, 0, 5, 1, 6, 1, 0,   0,  2,  1,  0);
    cyc("alu.dep3",  1, 0, 0, 0, 5, 1, 6, 1, 0,   0,  0,  2,  0);
    cyc("alu.dep4",  1, 0, 0, 0, 6, 1, 0, 0, 0,   0,  0,  0,  0);

    // Load-use: one stall cycle, then forwarding stage 1 and then stage 2.
    cyc("ld.issue",  1, 1, 1, 7, 0, 0, 0, 0, 0,   0,  0,  0,  1);
    cyc("ld.use0",   1, 0, 0, 0, 7, 1, 0, 0, 0,   1, -1, -1,  0);
    cyc("ld.use1",   1, 0, 0, 0, 7, 1, 0, 0, 0,   0,  1,  0,  0);
    cyc("ld.use2",   1, 0, 0, 0, 0, 0, 7, 1, 0,   0,  0,  2,  0);

    // WAW after a load with default latencies: no stall.
    cyc("waw.ld",    1, 1, 1, 3, 0, 0, 0, 0, 0,   0,  0,  0,  1);
    cyc("waw.alu",   1, 1, 0, 3, 0, 0, 0, 0, 0,   0,  0,  0,  0);
    cyc("waw.read",  1, 0, 0, 0, 3, 1, 0, 0, 0,   0,  1,  0,  0);

    // A source equal to its own rd sees the older producer.
    cyc("self.ld",   1, 1, 1, 8, 0, 0, 0, 0, 0,   0,  0,  0,  1);
    cyc("self.st",   1, 1, 0, 8, 8, 1, 0, 0, 0,   1, -1, -1,  0);
    cyc("self.go",   1, 1, 0, 8, 8, 1, 0, 0, 0,   0,  1,  0,  0);
    cyc("self.new",  1, 0, 0, 0, 8, 1, 0, 0, 0,   0,  1,  0,  0);

    // LOAD_LAT=3 instance: WAW stalls one cycle, load-use stalls two cycles.
    tgt = 1;
    cyc("b.waw.ld",  1, 1, 1, 3, 0, 0, 0, 0, 0,   0,  0,  0,  1);
    cyc("b.waw.st",  1, 1, 0, 3, 0, 0, 0, 0, 0,   1, -1, -1,  1);
    cyc("b.waw.go",  1, 1, 0, 3, 0, 0, 0, 0, 0,   0,  0,  0,  0);
    cyc("b.waw.rd",  1, 0, 0, 0, 3, 1, 0, 0, 0,   0,  1,  0,  0);
    cyc("b.ld.iss",  1, 1, 1, 9, 0, 0, 0, 0, 0,   0,  0,  0,  1);
    cyc("b.ld.st1",  1, 0, 0, 0, 9, 1, 0, 0, 0,   1, -1, -1,  1);
    cyc("b.ld.st2",  1, 0, 0, 0, 9, 1, 0, 0, 0,   1, -1, -1,  0);
    cyc("b.ld.go",   1, 0, 0, 0, 9, 1, 0, 0, 0,   0,  1,  0,  0);
    tgt = 0;

    // Flush drops the in-flight load and forces stall low in the flush cycle.
    cyc("fl.ld",     1, 1, 1, 4, 0, 0, 0, 0, 0,   0,  0,  0,  1);
    cyc("fl.flush",  1, 0, 0, 0, 4, 1, 0, 0, 1,   0, -1, -1,  0);
    cyc("fl.read",   1, 0, 0, 0, 4, 1, 0, 0, 0,   0,  0,  0,  0);

    // Register 0 is never tracked.
    cyc("r0.write",  1, 1, 1, 0, 0, 1, 0, 0, 0,   0,  0,  0,  0);
    cyc("r0.read",   1, 0, 0, 0, 0, 1, 0, 1, 0,   0,  0,  0,  0);

    // Asynchronous reset with loads in flight on the LOAD_LAT=3 instance.
    tgt = 1;
    cyc("ar.ld11",   1, 1, 1, 11, 0, 0, 0, 0, 0,  0,  0,  0,  1);
    cyc("ar.ld12",   1, 1, 1, 12, 0, 0, 0, 0, 0,  0,  0,  0,  2);
    cyc("ar.ld13",   1, 1, 1, 13, 0, 0, 0, 0, 0,  0,  0,  0,  2);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 0, 13, 1'b1, 12, 1'b1, 1'b0);
    #1;
    check("ar.pre.stall", int'(bus_b.stall), 1);
    #1;
    rst = 1'b1;
    #1;
    check("ar.stall", int'(bus_b.stall), 0);
    check("ar.pend", int'(bus_b.pending_cnt), 0);
    check("ar.fwd1", int'(bus_b.fwd1), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc("ar.after",  1, 0, 0, 0, 12, 1, 13, 1, 0, 0,  0,  0,  0);
    tgt = 0;
    cyc("ar.a.read", 1, 0, 0, 0, 5, 1, 7, 1, 0,   0,  0,  0,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
